// File: rtl/pipe_ctrl_unit_if.sv
// Handshake/bus bundle for pipe_ctrl_unit: ID-stage decode inputs and the
// per-stage control registers plus front-end stall/flush controls.
interface pipe_ctrl_unit_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [5:0]            id_opcode;
  logic [5:0]            id_funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  ex_branch_taken;

  logic [9:0]            ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [3:0]            mem_ctrl;
  logic [1:0]            wb_ctrl;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  id_illegal;

  modport master (
    output id_valid, id_opcode, id_funct, id_rs, id_rt, ex_branch_taken,
    input  ex_ctrl, ex_rt, mem_ctrl, wb_ctrl, pc_write, ifid_write,
           ifid_flush, id_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs, id_rt, ex_branch_taken,
    output ex_ctrl, ex_rt, mem_ctrl, wb_ctrl, pc_write, ifid_write,
           ifid_flush, id_illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control regs,
// branch/jump flush and (when LOAD_USE_STALL_EN is defined) load-use stall.
module pipe_ctrl_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned RA_ADDR    = 31
) (
  input logic             clk,
  input logic             rst_n,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  if (RA_ADDR >= (32'd1 << REG_ADDR_W)) begin : g_ra_addr_range
    $error("RA_ADDR does not fit in REG_ADDR_W bits");
  end

  logic [9:0]            ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [3:0]            ex_mem_q, ex_mem_d;
  logic [1:0]            ex_wb_q, ex_wb_d;
  logic [3:0]            mem_ctrl_q;
  logic [1:0]            mem_wb_q;
  logic [1:0]            wb_ctrl_q;
  logic                  id_illegal_q, id_illegal_d;

  logic [9:0] dec_ctrl;
  logic [3:0] dec_mem;
  logic [1:0] dec_wb;
  logic       dec_legal;
  logic       dec_uses_rt;
  logic       load_use;
  logic       branch_flush;
  logic       stall;
  logic       jump_flush;
  logic       bubble;

  // ctrl: [9:8] jump, [7:6] branch, [5] alu_src, [4:2] alu_op, [1:0] reg_dst
  always_comb begin
    dec_ctrl    = '0;
    dec_mem     = '0;
    dec_wb      = '0;
    dec_legal   = 1'b1;
    dec_uses_rt = 1'b0;
    case (bus.id_opcode)
      OP_RTYPE: begin
        if (bus.id_funct == FN_JR) begin
          dec_ctrl[9:8] = 2'b11;
        end else begin
          dec_ctrl[1:0] = 2'b01;
          dec_ctrl[4:2] = 3'b010;
          dec_wb[1]     = 1'b1;
          dec_uses_rt   = 1'b1;
        end
      end
      OP_LW, OP_LB, OP_LH: begin
        dec_mem[1:0]  = (bus.id_opcode == OP_LW) ? 2'b01 :
                        (bus.id_opcode == OP_LB) ? 2'b10 : 2'b11;
        dec_ctrl[5]   = 1'b1;
        dec_wb        = 2'b11;
      end
      OP_SW, OP_SB, OP_SH: begin
        dec_mem[3:2]  = (bus.id_opcode == OP_SW) ? 2'b01 :
                        (bus.id_opcode == OP_SB) ? 2'b10 : 2'b11;
        dec_ctrl[5]   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_ctrl[7:6] = (bus.id_opcode == OP_BEQ) ? 2'b01 : 2'b10;
        dec_ctrl[4:2] = 3'b001;
        dec_uses_rt   = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec_ctrl[5]   = 1'b1;
        dec_ctrl[4:2] = (bus.id_opcode == OP_ADDI) ? 3'b000 :
                        (bus.id_opcode == OP_ANDI) ? 3'b011 :
                        (bus.id_opcode == OP_ORI)  ? 3'b100 : 3'b101;
        dec_wb[1]     = 1'b1;
      end
      OP_J: begin
        dec_ctrl[9:8] = 2'b01;
      end
      OP_JAL: begin
        dec_ctrl[9:8] = 2'b10;
        dec_ctrl[1:0] = 2'b10;
        dec_wb[1]     = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

`ifdef LOAD_USE_STALL_EN
  always_comb begin
    load_use = bus.id_valid && (ex_mem_q[1:0] != 2'b00) && (ex_rt_q != '0) &&
               ((ex_rt_q == bus.id_rs) || (dec_uses_rt && (ex_rt_q == bus.id_rt)));
  end
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{bus.id_rs, dec_uses_rt};
  assign load_use = 1'b0;
`endif

  // Branch flush wins over the stall; a pending stall holds off the jump flush.
  always_comb begin
    branch_flush = (ex_ctrl_q[7:6] != 2'b00) && bus.ex_branch_taken;
    stall        = !branch_flush && load_use;
    jump_flush   = !branch_flush && !stall && bus.id_valid && (dec_ctrl[9:8] != 2'b00);
    bubble       = !bus.id_valid || branch_flush || stall;

    ex_ctrl_d    = bubble ? '0 : dec_ctrl;
    ex_mem_d     = bubble ? '0 : dec_mem;
    ex_wb_d      = bubble ? '0 : dec_wb;
    ex_rt_d      = (bubble || !dec_legal) ? '0 : bus.id_rt;
    id_illegal_d = bus.id_valid && !dec_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q    <= '0;
      ex_rt_q      <= '0;
      ex_mem_q     <= '0;
      ex_wb_q      <= '0;
      mem_ctrl_q   <= '0;
      mem_wb_q     <= '0;
      wb_ctrl_q    <= '0;
      id_illegal_q <= 1'b0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rt_q      <= ex_rt_d;
      ex_mem_q     <= ex_mem_d;
      ex_wb_q      <= ex_wb_d;
      mem_ctrl_q   <= ex_mem_q;
      mem_wb_q     <= ex_wb_q;
      wb_ctrl_q    <= mem_wb_q;
      id_illegal_q <= id_illegal_d;
    end
  end

  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_rt      = ex_rt_q;
  assign bus.mem_ctrl   = mem_ctrl_q;
  assign bus.wb_ctrl    = wb_ctrl_q;
  assign bus.id_illegal = id_illegal_q;
  // Front-end controls are forced to their idle values while reset is held.
  assign bus.pc_write   = !rst_n || !stall;
  assign bus.ifid_write = !rst_n || !stall;
  assign bus.ifid_flush = rst_n && (branch_flush || jump_flush);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode table, hand-written hazard
// and reset sequences, then random traffic against a stage-record model.
module tb_pipe_ctrl_unit;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_ctrl_unit_if #(.REG_ADDR_W(5)) bus ();

  pipe_ctrl_unit #(.REG_ADDR_W(5), .RA_ADDR(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] branch;
    logic [1:0] jump;
    logic [1:0] mem_read;
    logic [1:0] mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       legal;
  } dec_t;

  typedef struct {
    logic       valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [9:0] ctrl;
    logic [3:0] mem;
    logic [1:0] wb;
    logic       ill;
    logic       flush;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference decode written straight from the instruction table.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      6'h00: if (fn == 6'h08) d.jump = 2'd3;
             else begin d.reg_dst = 2'd1; d.alu_op = 3'd2; d.reg_write = 1'b1; end
      6'h23: begin d.mem_read = 2'd1; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1; end
      6'h20: begin d.mem_read = 2'd2; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1; end
      6'h21: begin d.mem_read = 2'd3; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1; end
      6'h2B: begin d.mem_write = 2'd1; d.alu_src = 1'b1; end
      6'h28: begin d.mem_write = 2'd2; d.alu_src = 1'b1; end
      6'h29: begin d.mem_write = 2'd3; d.alu_src = 1'b1; end
      6'h04: begin d.branch = 2'd1; d.alu_op = 3'd1; end
      6'h05: begin d.branch = 2'd2; d.alu_op = 3'd1; end
      6'h08: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = 3'd0; end
      6'h0C: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = 3'd3; end
      6'h0D: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = 3'd4; end
      6'h0F: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = 3'd5; end
      6'h02: d.jump = 2'd1;
      6'h03: begin d.jump = 2'd2; d.reg_dst = 2'd2; d.reg_write = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic bit reads_rt(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00 && fn != 6'h08) || op == 6'h2B || op == 6'h28 ||
           op == 6'h29 || op == 6'h04 || op == 6'h05;
  endfunction

  function automatic logic [9:0] ctrl_of(input dec_t d);
    return {d.jump, d.branch, d.alu_src, d.alu_op, d.reg_dst};
  endfunction
  function automatic logic [3:0] mem_of(input dec_t d);
    return {d.mem_write, d.mem_read};
  endfunction
  function automatic logic [1:0] wb_of(input dec_t d);
    return {d.reg_write, d.mem_to_reg};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic taken);
    bus.id_valid        = v;
    bus.id_opcode       = op;
    bus.id_funct        = fn;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.ex_branch_taken = taken;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];
  logic [5:0] oplist[16];

  dec_t       m_ex, m_mem, m_wb, n_ex, d;
  logic [4:0] m_rt, n_rt;
  logic       m_ill, n_ill;
  bit         bflush, hazard, stall, jflush;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b1, 6'h00, 6'h20, 10'h009, 4'h0, 2'b10, 1'b0, 1'b0}; // add
    vecs[1]  = '{1'b1, 6'h00, 6'h08, 10'h300, 4'h0, 2'b00, 1'b0, 1'b1}; // jr
    vecs[2]  = '{1'b1, 6'h23, 6'h00, 10'h020, 4'h1, 2'b11, 1'b0, 1'b0}; // lw
    vecs[3]  = '{1'b1, 6'h20, 6'h00, 10'h020, 4'h2, 2'b11, 1'b0, 1'b0}; // lb
    vecs[4]  = '{1'b1, 6'h21, 6'h00, 10'h020, 4'h3, 2'b11, 1'b0, 1'b0}; // lh
    vecs[5]  = '{1'b1, 6'h2B, 6'h00, 10'h020, 4'h4, 2'b00, 1'b0, 1'b0}; // sw
    vecs[6]  = '{1'b1, 6'h28, 6'h00, 10'h020, 4'h8, 2'b00, 1'b0, 1'b0}; // sb
    vecs[7]  = '{1'b1, 6'h29, 6'h00, 10'h020, 4'hC, 2'b00, 1'b0, 1'b0}; // sh
    vecs[8]  = '{1'b1, 6'h04, 6'h00, 10'h044, 4'h0, 2'b00, 1'b0, 1'b0}; // beq
    vecs[9]  = '{1'b1, 6'h05, 6'h00, 10'h084, 4'h0, 2'b00, 1'b0, 1'b0}; // bne
    vecs[10] = '{1'b1, 6'h08, 6'h08, 10'h020, 4'h0, 2'b10, 1'b0, 1'b0}; // addi
    vecs[11] = '{1'b1, 6'h0C, 6'h00, 10'h02C, 4'h0, 2'b10, 1'b0, 1'b0}; // andi
    vecs[12] = '{1'b1, 6'h0D, 6'h00, 10'h030, 4'h0, 2'b10, 1'b0, 1'b0}; // ori
    vecs[13] = '{1'b1, 6'h0F, 6'h00, 10'h034, 4'h0, 2'b10, 1'b0, 1'b0}; // lui
    vecs[14] = '{1'b1, 6'h02, 6'h00, 10'h100, 4'h0, 2'b00, 1'b0, 1'b1}; // j
    vecs[15] = '{1'b1, 6'h03, 6'h00, 10'h202, 4'h0, 2'b10, 1'b0, 1'b1}; // jal
    vecs[16] = '{1'b1, 6'h3F, 6'h00, 10'h000, 4'h0, 2'b00, 1'b1, 1'b0}; // illegal
    vecs[17] = '{1'b0, 6'h23, 6'h00, 10'h000, 4'h0, 2'b00, 1'b0, 1'b0}; // invalid
    oplist = '{6'h00, 6'h00, 6'h23, 6'h20, 6'h21, 6'h2B, 6'h28, 6'h29,
               6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03};

    // Reset with a jal sitting in ID: front-end controls must stay idle.
    rst_n = 1'b0;
    drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 1'b0);
    #13;
    chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
    chk("rst_ex_rt", 32'(bus.ex_rt), 32'h0);
    chk("rst_mem_ctrl", 32'(bus.mem_ctrl), 32'h0);
    chk("rst_wb_ctrl", 32'(bus.wb_ctrl), 32'h0);
    chk("rst_id_illegal", 32'(bus.id_illegal), 32'h0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'h1);
    chk("rst_ifid_write", 32'(bus.ifid_write), 32'h1);
    chk("rst_ifid_flush", 32'(bus.ifid_flush), 32'h0);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].fn, 5'd0, 5'd0, 1'b0);
      #1;
      chk($sformatf("tbl%0d_flush", i), 32'(bus.ifid_flush), 32'(vecs[i].flush));
      chk($sformatf("tbl%0d_pc_write", i), 32'(bus.pc_write), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ex_ctrl", i), 32'(bus.ex_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("tbl%0d_illegal", i), 32'(bus.id_illegal), 32'(vecs[i].ill));
      drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_mem_ctrl", i), 32'(bus.mem_ctrl), 32'(vecs[i].mem));
      chk($sformatf("tbl%0d_illegal_drop", i), 32'(bus.id_illegal), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wb_ctrl", i), 32'(bus.wb_ctrl), 32'(vecs[i].wb));
    end

    // lw $8 followed by add $9,$8,$1.
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd8, 1'b0);
    @(posedge clk); #1;
    chk("lu_ex_rt", 32'(bus.ex_rt), 32'd8);
    drive(1'b1, 6'h00, 6'h20, 5'd8, 5'd1, 1'b0);
    #1;
    chk("lu_pc_write", 32'(bus.pc_write), 32'(!STALL_EN));
    chk("lu_ifid_write", 32'(bus.ifid_write), 32'(!STALL_EN));
    @(posedge clk); #1;
    chk("lu_ex_ctrl", 32'(bus.ex_ctrl), STALL_EN ? 32'h0 : 32'h009);
    chk("lu_mem_ctrl", 32'(bus.mem_ctrl), 32'h1);
    chk("lu_pc_write_after", 32'(bus.pc_write), 32'h1);
    @(posedge clk); #1;
    chk("lu_add_in_ex", 32'(bus.ex_ctrl), 32'h009);
    idle_cycles(2);

    // Taken beq in EX squashes a jump in ID.
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 1'b1);
    #1;
    chk("br_flush", 32'(bus.ifid_flush), 32'h1);
    chk("br_pc_write", 32'(bus.pc_write), 32'h1);
    @(posedge clk); #1;
    chk("br_bubble", 32'(bus.ex_ctrl), 32'h0);
    drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 1'b1);
    #1;
    chk("br_jump_flush_after", 32'(bus.ifid_flush), 32'h1);
    @(posedge clk); #1;
    chk("br_jump_in_ex", 32'(bus.ex_ctrl), 32'h100);
    idle_cycles(2);

    // Not-taken branch in EX leaves a plain add undisturbed.
    drive(1'b1, 6'h05, 6'h00, 5'd1, 5'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 6'h00, 6'h20, 5'd3, 5'd4, 1'b0);
    #1;
    chk("bnt_flush", 32'(bus.ifid_flush), 32'h0);
    @(posedge clk); #1;
    chk("bnt_ex_ctrl", 32'(bus.ex_ctrl), 32'h009);
    idle_cycles(2);

    // jal: flush now, link write reaches WB three edges later.
    drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 1'b0);
    #1;
    chk("jal_flush", 32'(bus.ifid_flush), 32'h1);
    @(posedge clk); #1;
    chk("jal_reg_dst", 32'(bus.ex_ctrl[1:0]), 32'h2);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("jal_wb_early", 32'(bus.wb_ctrl), 32'h0);
    @(posedge clk); #1;
    chk("jal_wb", 32'(bus.wb_ctrl), 32'h2);
    idle_cycles(2);

    // Reset asserted in the middle of a load-use cycle.
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd8, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 6'h00, 6'h20, 5'd8, 5'd1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
    chk("rstmid_ex_rt", 32'(bus.ex_rt), 32'h0);
    chk("rstmid_pc_write", 32'(bus.pc_write), 32'h1);
    chk("rstmid_ifid_write", 32'(bus.ifid_write), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrel_pc_write", 32'(bus.pc_write), 32'h1);
    @(posedge clk); #1;
    chk("rstrel_ex_ctrl", 32'(bus.ex_ctrl), 32'h009);
    idle_cycles(3);

    // Random traffic against the stage-record model; pipeline is empty here.
    m_ex = '0; m_mem = '0; m_wb = '0; m_rt = '0; m_ill = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op, fn;
      logic       v;
      v  = ($urandom_range(0, 7) != 0);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : oplist[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      drive(v, op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      #1;
      d      = decode(op, fn);
      bflush = (m_ex.branch != 2'd0) && bus.ex_branch_taken;
      hazard = STALL_EN && v && (m_ex.mem_read != 2'd0) && (m_rt != 5'd0) &&
               (m_rt == bus.id_rs || (m_rt == bus.id_rt && reads_rt(op, fn)));
      stall  = !bflush && hazard;
      jflush = !bflush && !stall && v && (d.jump != 2'd0);
      chk("rnd_pc_write", 32'(bus.pc_write), 32'(!stall));
      chk("rnd_ifid_write", 32'(bus.ifid_write), 32'(!stall));
      chk("rnd_ifid_flush", 32'(bus.ifid_flush), 32'(bflush || jflush));
      if (v && !bflush && !stall && d.legal) begin
        n_ex = d;
        n_rt = bus.id_rt;
      end else begin
        n_ex = '0;
        n_rt = '0;
      end
      n_ill = v && !d.legal;
      @(posedge clk); #1;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = n_ex;
      m_rt  = n_rt;
      m_ill = n_ill;
      chk("rnd_ex_ctrl", 32'(bus.ex_ctrl), 32'(ctrl_of(m_ex)));
      chk("rnd_ex_rt", 32'(bus.ex_rt), 32'(m_rt));
      chk("rnd_mem_ctrl", 32'(bus.mem_ctrl), 32'(mem_of(m_mem)));
      chk("rnd_wb_ctrl", 32'(bus.wb_ctrl), 32'(wb_of(m_wb)));
      chk("rnd_id_illegal", 32'(bus.id_illegal), 32'(m_ill));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter RA_ADDR, default 31, link register written by jal.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  ID-stage instruction valid.
REQ-006 id_opcode  in  6  instruction [31:26].
REQ-007 id_funct  in  6  instruction [5:0].
REQ-008 id_rs, id_rt  in  REG_ADDR_W each  ID source fields.
REQ-009 ex_branch_taken  in  1  EX comparator result for the branch now in EX.
REQ-010 ex_ctrl  out  10  ID/EX reg: [1:0] reg_dst (00 rt, 01 rd, 10 RA_ADDR), [4:2] alu_op, [5] alu_src, [7:6] branch (01 beq, 10 bne), [9:8] jump (01 j, 10 jal, 11 jr).
REQ-011 ex_rt  out  REG_ADDR_W  rt field registered into EX.
REQ-012 mem_ctrl  out  4  EX/MEM reg: [1:0] mem_read (01 word, 10 byte, 11 half), [3:2] mem_write (same coding).
REQ-013 wb_ctrl  out  2  MEM/WB reg: [0] mem_to_reg, [1] reg_write.
REQ-014 pc_write, ifid_write, ifid_flush  out  1 each  front-end controls, combinational.
REQ-015 id_illegal  out  1  registered one-cycle pulse on undecodable valid opcode.

Function
REQ-016 Decode (ID, combinational): op 000000 funct!=001000 R-type: reg_dst 01, alu_op 010, reg_write; op 000000 funct 001000 jr: jump 11; lw 100011/lb 100000/lh 100001: mem_read 01/10/11, alu_src, mem_to_reg, reg_write, alu_op 000; sw 101011/sb 101000/sh 101001: mem_write 01/10/11, alu_src, alu_op 000; beq 000100/bne 000101: branch 01/10, alu_op 001; addi 001000, andi 001100, ori 001101, lui 001111: alu_src, reg_write, alu_op 000/011/100/101; j 000010: jump 01; jal 000011: jump 10, reg_dst 10, reg_write; every unlisted field zero.
REQ-017 Any other opcode with id_valid=1 SHALL decode as bubble (all zero) and set id_illegal next cycle.
REQ-018 Control SHALL advance ID->EX->MEM->WB one stage per clock; no hold beyond ID/EX; mem_ctrl/wb_ctrl carry the fields of the instruction one/two stages ahead.
REQ-019 Load-use hazard: EX-stage mem_read!=00, ex_rt!=0, and ex_rt==id_rs, or ex_rt==id_rt for R-type/store/beq/bne/jr-excluded; then pc_write=0, ifid_write=0, bubble into ID/EX, exactly one cycle.
REQ-020 Jump in ID (jump!=00, no stall): ifid_flush=1 same cycle; jump itself enters ID/EX.
REQ-021 EX branch taken (ex_ctrl branch!=00 and ex_branch_taken=1): ifid_flush=1 and bubble into ID/EX next edge; overrides stall and jump flush.
REQ-022 Priority: branch flush > load-use stall > jump flush; stall suppresses jump flush until resolved.
REQ-023 id_valid=0 SHALL enter ID/EX as bubble and never raise stall or flush.

Reset
REQ-024 rst_n low SHALL immediately clear ex_ctrl, ex_rt, mem_ctrl, wb_ctrl, id_illegal to 0; pc_write=ifid_write=1, ifid_flush=0.
REQ-025 Reset mid-stall SHALL discard the stall; first cycle after release decodes normally.

Configuration
REQ-026 LOAD_USE_STALL_EN defined: REQ-019 active; undefined: pc_write=ifid_write=1 always, no load-use bubbles, software schedules delay; all other behaviour identical.

Verification
REQ-027 lw $8 then add $9,$8,$1 -> one cycle pc_write=0, ifid_write=0, ex_ctrl=0; add reaches EX next cycle (macro off: no stall).
REQ-028 beq in EX with ex_branch_taken=1 while lw-use stall pending -> ifid_flush=1, bubble, stall dropped.
REQ-029 jal in ID -> ifid_flush=1 same cycle; wb_ctrl=2'b10 three edges later, ex_ctrl reg_dst=10.
REQ-030 opcode 111111, id_valid=1 -> ex_ctrl/mem_ctrl/wb_ctrl 0, id_illegal pulses one cycle.
REQ-031 op 000000 funct 001000 (jr) -> ex_ctrl jump=11, reg_write 0; op 001000 (addi) -> alu_src, reg_write, alu_op 000.
REQ-032 rst_n low during stall -> all registered outputs 0 asynchronously, pc_write=1.
